// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: decode-stage controller for the immediate extender.
// Decodes the opcode into Ext controls, then captures the extended
// immediate into a 2-entry skid-buffered ID/EX stage.
// Optional feature macro: IMM_CHECK_EN (adds sticky imm_err output driven
// by an internal reference extender).
module id_imm_ctrl #(
    parameter int          BRANCH_SHIFT = 2,
    parameter logic [31:0] RESET_IMM    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        id_ready,
    input  logic        flush,
    output logic        ext_op,
    output logic        ext_high,
    output logic [15:0] ext_in,
    input  logic [31:0] ext_out,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic [31:0] ex_imm,
    output logic [1:0]  ex_kind
`ifdef IMM_CHECK_EN
    ,
    output logic        imm_err
`endif
);

    // Immediate kinds as seen by the EX stage
    localparam logic [1:0] KIND_NONE   = 2'd0;
    localparam logic [1:0] KIND_ARITH  = 2'd1;
    localparam logic [1:0] KIND_LOGIC  = 2'd2;
    localparam logic [1:0] KIND_BRANCH = 2'd3;

    // Opcodes that carry a 16-bit immediate
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;
    localparam logic [5:0] OPC_ANDI  = 6'b001100;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_XORI  = 6'b001110;
    localparam logic [5:0] OPC_LUI   = 6'b001111;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    // Decode results
    logic [5:0]  w_opcode;
    logic        w_op;
    logic        w_high;
    logic [1:0]  w_kind;
    logic [31:0] w_imm;

    // Handshake
    logic        w_accept;
    logic        w_pop;

    // Buffer state and entries; head entry drives ex_* directly
    buf_state_t  r_state;
    logic        r_id_ready;
    logic        r_ex_valid;
    logic [31:0] r_head_imm;
    logic [1:0]  r_head_kind;
    logic [31:0] r_tail_imm;
    logic [1:0]  r_tail_kind;

    assign w_opcode = id_instr[31:26];

    // Opcode decode into Ext controls and the immediate kind
    always_comb begin
        w_op   = 1'b0;
        w_high = 1'b0;
        w_kind = KIND_NONE;
        case (w_opcode)
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
                w_op   = 1'b1;
                w_kind = KIND_ARITH;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                w_kind = KIND_LOGIC;
            end
            OPC_LUI: begin
                w_high = 1'b1;
                w_kind = KIND_ARITH;
            end
            OPC_BEQ, OPC_BNE: begin
                w_op   = 1'b1;
                w_kind = KIND_BRANCH;
            end
            default: begin
                w_op   = 1'b0;
                w_high = 1'b0;
                w_kind = KIND_NONE;
            end
        endcase
    end

    // Branch offsets are word-scaled after extension; bits shifted past
    // bit 31 are dropped.
    always_comb begin
        w_imm = ext_out;
        if (w_kind == KIND_BRANCH) begin
            w_imm = ext_out << BRANCH_SHIFT;
        end
    end

    // Ext is purely combinational, so its controls follow id_instr ungated
    assign ext_op   = w_op;
    assign ext_high = w_high;
    assign ext_in   = id_instr[15:0];

    // id_ready comes straight from a register, so it has no path from ex_ready
    assign w_accept = id_valid && r_id_ready;
    assign w_pop    = r_ex_valid && ex_ready;

    assign id_ready = r_id_ready;
    assign ex_valid = r_ex_valid;
    assign ex_imm   = r_head_imm;
    assign ex_kind  = r_head_kind;

    // Buffer FSM: state, entries and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_id_ready  <= 1'b1;
            r_ex_valid  <= 1'b0;
            r_head_imm  <= RESET_IMM;
            r_head_kind <= KIND_NONE;
            r_tail_imm  <= RESET_IMM;
            r_tail_kind <= KIND_NONE;
        end else if (flush) begin
            // Flush wins over any accept or pop on the same edge
            r_state     <= ST_EMPTY;
            r_id_ready  <= 1'b1;
            r_ex_valid  <= 1'b0;
            r_head_imm  <= RESET_IMM;
            r_head_kind <= KIND_NONE;
            r_tail_imm  <= RESET_IMM;
            r_tail_kind <= KIND_NONE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state     <= ST_ONE;
                        r_ex_valid  <= 1'b1;
                        r_id_ready  <= 1'b1;
                        r_head_imm  <= w_imm;
                        r_head_kind <= w_kind;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        // Second entry queues behind the head; stop accepting
                        r_state     <= ST_TWO;
                        r_id_ready  <= 1'b0;
                        r_tail_imm  <= w_imm;
                        r_tail_kind <= w_kind;
                    end else if (!w_accept && w_pop) begin
                        r_state     <= ST_EMPTY;
                        r_ex_valid  <= 1'b0;
                        r_head_imm  <= RESET_IMM;
                        r_head_kind <= KIND_NONE;
                    end else if (w_accept && w_pop) begin
                        // Head leaves while the new entry takes its place
                        r_head_imm  <= w_imm;
                        r_head_kind <= w_kind;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        r_state     <= ST_ONE;
                        r_id_ready  <= 1'b1;
                        r_head_imm  <= r_tail_imm;
                        r_head_kind <= r_tail_kind;
                        r_tail_imm  <= RESET_IMM;
                        r_tail_kind <= KIND_NONE;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_id_ready  <= 1'b1;
                    r_ex_valid  <= 1'b0;
                    r_head_imm  <= RESET_IMM;
                    r_head_kind <= KIND_NONE;
                    r_tail_imm  <= RESET_IMM;
                    r_tail_kind <= KIND_NONE;
                end
            endcase
        end
    end

`ifdef IMM_CHECK_EN
    logic [31:0] w_ref_ext;
    logic        r_imm_err;

    // Reference extender: what Ext should return for the current controls
    always_comb begin
        if (w_high) begin
            w_ref_ext = {id_instr[15:0], 16'h0000};
        end else if (w_op) begin
            w_ref_ext = {{16{id_instr[15]}}, id_instr[15:0]};
        end else begin
            w_ref_ext = {16'h0000, id_instr[15:0]};
        end
    end

    // Sticky mismatch flag, sampled on every accepted instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_err <= 1'b0;
        end else if (w_accept && (ext_out != w_ref_ext)) begin
            r_imm_err <= 1'b1;
        end
    end

    assign imm_err = r_imm_err;
`endif

endmodule
